// File: rtl/io_burst_sequencer.sv
// Round-robin owner of the shared IO address counter: grants one of two requesters a
// burst of Len beats stepping up or down. Optional stall abort under IO_SEQ_TIMEOUT_EN.
module io_burst_sequencer #(
   parameter int ADDR_WIDTH     = 8,
   parameter int LEN_WIDTH      = 8,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  Req_0,
   input  logic [LEN_WIDTH-1:0]  Len_0,
   input  logic                  Dir_0,
   input  logic                  Req_1,
   input  logic [LEN_WIDTH-1:0]  Len_1,
   input  logic                  Dir_1,
   input  logic                  Beat_Ready,
   output logic [1:0]            Grant,
   output logic                  Busy,
   output logic [ADDR_WIDTH-1:0] Addr,
   output logic                  Addr_Valid,
   output logic [1:0]            Done,
   output logic                  Timeout,
   output logic [1:0]            dbg_state
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

   state_t                state, state_n;
   logic [1:0]            grant_n, done_n;
   logic [ADDR_WIDTH-1:0] addr_n;
   logic                  valid_n, timeout_n;
   logic                  rr_last, rr_n;
   logic [LEN_WIDTH-1:0]  len_q, len_n;
   logic                  dir_q, dir_n;
   logic                  pick_1;
   logic [LEN_WIDTH-1:0]  win_len;
   logic                  win_dir;
   logic [ADDR_WIDTH-1:0] last_up;

`ifdef IO_SEQ_TIMEOUT_EN
   localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [STALL_W-1:0] stall, stall_n;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

   // Requester 1 wins alone, or on a tie when requester 0 owned the previous burst.
   assign pick_1  = Req_1 && (!Req_0 || !rr_last);
   assign win_len = pick_1 ? Len_1 : Len_0;
   assign win_dir = pick_1 ? Dir_1 : Dir_0;
   assign last_up = ADDR_WIDTH'(len_q) - ADDR_WIDTH'(1);

   assign Busy      = (state != S_IDLE);
   assign dbg_state = state;

   // Handshake: a beat moves on any cycle with Addr_Valid && Beat_Ready; Addr and
   // Addr_Valid hold otherwise, and Addr_Valid never drops before the last beat moves.
   always_comb begin
      state_n   = state;
      grant_n   = Grant;
      addr_n    = Addr;
      valid_n   = Addr_Valid;
      done_n    = 2'b00;
      timeout_n = 1'b0;
      rr_n      = rr_last;
      len_n     = len_q;
      dir_n     = dir_q;
`ifdef IO_SEQ_TIMEOUT_EN
      stall_n   = stall;
`endif
      case (state)
         S_IDLE: begin
            grant_n = 2'b00;
            valid_n = 1'b0;
`ifdef IO_SEQ_TIMEOUT_EN
            stall_n = '0;
`endif
            if (Req_0 || Req_1) begin
               grant_n = pick_1 ? 2'b10 : 2'b01;
               rr_n    = pick_1;
               len_n   = win_len;
               dir_n   = win_dir;
               if (win_len == '0) begin
                  state_n = S_DONE;
                  done_n  = grant_n;
               end else begin
                  state_n = S_RUN;
                  valid_n = 1'b1;
                  addr_n  = win_dir ? '0 : ADDR_WIDTH'(win_len) - ADDR_WIDTH'(1);
               end
            end
         end
         S_RUN: begin
            if (Beat_Ready) begin
`ifdef IO_SEQ_TIMEOUT_EN
               stall_n = '0;
`endif
               if (dir_q ? (Addr == last_up) : (Addr == '0)) begin
                  state_n = S_DONE;
                  valid_n = 1'b0;
                  done_n  = Grant;
               end else begin
                  addr_n = dir_q ? Addr + ADDR_WIDTH'(1) : Addr - ADDR_WIDTH'(1);
               end
            end
`ifdef IO_SEQ_TIMEOUT_EN
            else if (stall == STALL_W'(TIMEOUT_CYCLES - 1)) begin
               state_n   = S_DONE;
               valid_n   = 1'b0;
               done_n    = Grant;
               timeout_n = 1'b1;
            end else begin
               stall_n = stall + STALL_W'(1);
            end
`endif
         end
         S_DONE: begin
            state_n = S_IDLE;
            grant_n = 2'b00;
         end
         default: begin
            state_n = S_IDLE;
            grant_n = 2'b00;
            valid_n = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state      <= S_IDLE;
         Grant      <= 2'b00;
         Addr       <= '0;
         Addr_Valid <= 1'b0;
         Done       <= 2'b00;
         Timeout    <= 1'b0;
         rr_last    <= 1'b1;
         len_q      <= '0;
         dir_q      <= 1'b0;
`ifdef IO_SEQ_TIMEOUT_EN
         stall      <= '0;
`endif
      end else begin
         state      <= state_n;
         Grant      <= grant_n;
         Addr       <= addr_n;
         Addr_Valid <= valid_n;
         Done       <= done_n;
         Timeout    <= timeout_n;
         rr_last    <= rr_n;
         len_q      <= len_n;
         dir_q      <= dir_n;
`ifdef IO_SEQ_TIMEOUT_EN
         stall      <= stall_n;
`endif
      end
   end

endmodule

// File: tb/tb_io_burst_sequencer.sv
// Bench for io_burst_sequencer: directed and randomized bursts against a queue-based
// model of arbitration and address sequences; honours IO_SEQ_TIMEOUT_EN when defined.
module tb_io_burst_sequencer;

   localparam int TMO = 16;

   logic       CLK = 1'b0;
   logic       RST;
   logic       Req_0, Req_1, Dir_0, Dir_1, Beat_Ready;
   logic [7:0] Len_0, Len_1;
   logic [1:0] Grant, Done, dbg_state;
   logic       Busy, Addr_Valid, Timeout;
   logic [7:0] Addr;

   int         n_cmp = 0;
   int         n_bad = 0;
   bit         rr_m;
   bit         rdy_pat[$];
   logic [7:0] exp_q[$];

   io_burst_sequencer #(.ADDR_WIDTH(8), .LEN_WIDTH(8), .TIMEOUT_CYCLES(TMO)) dut (
      .CLK(CLK), .RST(RST),
      .Req_0(Req_0), .Len_0(Len_0), .Dir_0(Dir_0),
      .Req_1(Req_1), .Len_1(Len_1), .Dir_1(Dir_1),
      .Beat_Ready(Beat_Ready), .Grant(Grant), .Busy(Busy), .Addr(Addr),
      .Addr_Valid(Addr_Valid), .Done(Done), .Timeout(Timeout), .dbg_state(dbg_state)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   // One arbitration + burst: the model picks the winner from the round-robin rule and
   // lists the addresses the burst must present, then each presented beat is checked.
   task automatic burst(input bit r0, input bit r1, input logic [7:0] l0, input logic [7:0] l1,
                        input bit d0, input bit d1, input int pct);
      bit         w, dir, br, abort;
      logic [7:0] len, last_addr;
      logic [1:0] oh;
      int         stalls, cyc;
      w   = r1 && (!r0 || !rr_m);
      len = w ? l1 : l0;
      dir = w ? d1 : d0;
      oh  = w ? 2'b10 : 2'b01;
      exp_q.delete();
      for (int i = 0; i < int'(len); i++)
         exp_q.push_back(dir ? 8'(i) : 8'(int'(len) - 1 - i));
      Req_0 = r0; Req_1 = r1; Len_0 = l0; Len_1 = l1; Dir_0 = d0; Dir_1 = d1;
      Beat_Ready = 1'b0;
      step();
      rr_m = w;
      chk("grant_at_start", Grant, oh);
      chk("busy_at_start", Busy, 1);
      stalls = 0; cyc = 0; abort = 0; last_addr = 8'h00;
      while (exp_q.size() > 0 && !abort) begin
         chk("addr_valid", Addr_Valid, 1);
         chk("addr", Addr, exp_q[0]);
         chk("done_in_run", Done, 0);
         chk("grant_in_run", Grant, oh);
         chk("timeout_in_run", Timeout, 0);
         last_addr = exp_q[0];
         // Inputs other than Beat_Ready are don't-care until the next idle cycle.
         Len_0 = 8'($urandom); Len_1 = 8'($urandom);
         Dir_0 = 1'($urandom); Dir_1 = 1'($urandom);
         Req_0 = 1'($urandom); Req_1 = 1'($urandom);
         if (rdy_pat.size() > 0) br = rdy_pat.pop_front();
         else br = ($urandom_range(99) < pct);
         Beat_Ready = br;
         if (br) begin
            void'(exp_q.pop_front());
            stalls = 0;
         end else begin
            stalls++;
`ifdef IO_SEQ_TIMEOUT_EN
            if (stalls == TMO) abort = 1;
`endif
         end
         step();
         cyc++;
         if (cyc > 2000) begin
            chk("burst_cycle_budget", cyc, 2000);
            break;
         end
      end
      chk("done_pulse", Done, oh);
      chk("done_grant", Grant, oh);
      chk("done_busy", Busy, 1);
      chk("done_valid", Addr_Valid, 0);
      chk("done_timeout", Timeout, abort);
      if (len != 0) chk("done_addr_hold", Addr, last_addr);
      Req_0 = 0; Req_1 = 0; Beat_Ready = 0;
      step();
      chk("idle_grant", Grant, 0);
      chk("idle_busy", Busy, 0);
      chk("idle_done", Done, 0);
      chk("idle_valid", Addr_Valid, 0);
      chk("idle_timeout", Timeout, 0);
   endtask

   initial begin
      RST = 1'b1; Req_0 = 0; Req_1 = 0; Dir_0 = 0; Dir_1 = 0; Beat_Ready = 0;
      Len_0 = 0; Len_1 = 0; rr_m = 1;
      #1;
      chk("rst_grant", Grant, 0);
      chk("rst_busy", Busy, 0);
      chk("rst_addr", Addr, 0);
      chk("rst_valid", Addr_Valid, 0);
      chk("rst_done", Done, 0);
      chk("rst_timeout", Timeout, 0);
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      step();
      chk("post_rst_grant", Grant, 0);

      // Up burst, always ready
      burst(1, 0, 8'd4, 8'd0, 1, 0, 100);
      // Down burst with stall pattern 1,0,1,1
      rdy_pat = '{1, 0, 1, 1};
      burst(0, 1, 8'd0, 8'd3, 0, 0, 100);
      // Contention: grants alternate
      burst(1, 1, 8'd2, 8'd3, 1, 0, 100);
      burst(1, 1, 8'd2, 8'd3, 1, 0, 100);
      burst(1, 1, 8'd2, 8'd3, 0, 1, 100);
      // Zero-length burst
      burst(1, 0, 8'd0, 8'd5, 1, 1, 100);

      // Asynchronous reset during beat 2 of a 5-beat burst
      Req_0 = 1; Req_1 = 0; Len_0 = 8'd5; Dir_0 = 1; Beat_Ready = 1;
      step();
      chk("arst_beat0", Addr, 0);
      step();
      chk("arst_beat1", Addr, 1);
      chk("arst_beat1_valid", Addr_Valid, 1);
      #2 RST = 1'b1;
      #1;
      chk("arst_grant", Grant, 0);
      chk("arst_busy", Busy, 0);
      chk("arst_addr", Addr, 0);
      chk("arst_valid", Addr_Valid, 0);
      chk("arst_done", Done, 0);
      @(negedge CLK);
      Req_0 = 0; Beat_Ready = 0;
      step();
      RST = 1'b0;
      rr_m = 1;
      step();
      chk("arst_no_done", Done, 0);
      chk("arst_idle_grant", Grant, 0);
      burst(1, 1, 8'd3, 8'd2, 1, 1, 100);

      // Max length in both directions
      burst(0, 1, 8'd1, 8'd255, 0, 1, 90);
      burst(1, 0, 8'd255, 8'd1, 0, 1, 90);

      // Randomized bursts
      for (int k = 0; k < 14; k++) begin
         bit         r0, r1;
         logic [7:0] l0, l1;
         int         sel;
         sel = $urandom_range(2);
         r0 = (sel != 1); r1 = (sel != 0);
         l0 = ($urandom_range(5) == 0) ? 8'd0 : 8'($urandom_range(1, 20));
         l1 = ($urandom_range(5) == 0) ? 8'd1 : 8'($urandom_range(0, 20));
         burst(r0, r1, l0, l1, 1'($urandom), 1'($urandom), $urandom_range(60, 100));
      end

      // Long stall: 100 cycles without Beat_Ready
      for (int i = 0; i < 100; i++) rdy_pat.push_back(0);
      burst(1, 0, 8'd4, 8'd0, 1, 0, 100);
      rdy_pat.delete();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "global time limit reached");
   end

endmodule
